// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with programmable modulus, clamped parallel
// load, count enable, wrap-or-saturate behaviour, terminal-count and carry
// flags, plus a Gray-coded view of the count.
module counter_updown_mod #(
  parameter int N        = 8,
  parameter int MOD      = 2**N,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         reset_in,
  input  logic         en_in,
  input  logic         load_in,
  input  logic         dir_in,
  input  logic [N-1:0] d_in,
  output logic [N-1:0] count_out,
  output logic         tc_out,
  output logic         carry_out,
  output logic [N-1:0] gray_out
);

  // Largest legal count, held one bit wider so MOD == 2**N still fits.
  localparam logic [N:0]   MAX_EXT = (N+1)'(MOD-1);
  localparam logic [N:0]   ONE_EXT = (N+1)'(1);
  localparam logic [N-1:0] ONE_N   = N'(1);

  logic [N-1:0] count_q, count_d;
  logic         carry_q, carry_d;

  logic [N:0]   cnt_ext;
  logic [N:0]   load_ext;
  logic [N:0]   up_ext;
  logic [N-1:0] dn_n;
  logic         at_top;
  logic         at_bot;

  // Widened forms let the incremented value and load value be compared
  // against MOD-1 without overflowing when MOD == 2**N.
  assign cnt_ext  = {1'b0, count_q};
  assign load_ext = {1'b0, d_in};
  assign up_ext   = cnt_ext + ONE_EXT;
  assign dn_n     = count_q - ONE_N;
  assign at_top   = (up_ext > MAX_EXT);
  assign at_bot   = (count_q == '0);

  // Terminal count follows the current direction immediately.
  assign tc_out    = dir_in ? at_top : at_bot;
  assign count_out = count_q;
  assign carry_out = carry_q;
  assign gray_out  = count_q ^ (count_q >> 1);

  // Next-state: load (clamped) beats enable; a step from terminal wraps or holds and raises carry.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (load_in) begin
      count_d = (load_ext > MAX_EXT) ? MAX_EXT[N-1:0] : d_in;
    end else if (en_in) begin
      if (tc_out) begin
        carry_d = 1'b1;
        if (!SATURATE) begin
          count_d = dir_in ? '0 : MAX_EXT[N-1:0];
        end
      end else begin
        count_d = dir_in ? up_ext[N-1:0] : dn_n;
      end
    end
  end

  // State register with synchronous reset dominating load and enable.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: four differently parameterised instances
// share one stimulus stream and are checked every cycle against an
// integer-arithmetic model, with directed sequences pinned by literals.
module tb_counter_updown_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_in, en_in, load_in, dir_in;
  logic [3:0] d_in;

  // A: N=3 MOD=6 wrap; B: N=3 MOD=8 saturate; C: N=3 MOD=8 wrap; D: N=4 MOD=11 wrap
  logic [2:0] cnt_a, gray_a, cnt_b, gray_b, cnt_c, gray_c;
  logic [3:0] cnt_d, gray_d;
  logic       tc_a, tc_b, tc_c, tc_d, car_a, car_b, car_c, car_d;

  counter_updown_mod #(.N(3), .MOD(6), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset_in(reset_in), .en_in(en_in), .load_in(load_in), .dir_in(dir_in),
    .d_in(d_in[2:0]), .count_out(cnt_a), .tc_out(tc_a), .carry_out(car_a), .gray_out(gray_a));
  counter_updown_mod #(.N(3), .MOD(8), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset_in(reset_in), .en_in(en_in), .load_in(load_in), .dir_in(dir_in),
    .d_in(d_in[2:0]), .count_out(cnt_b), .tc_out(tc_b), .carry_out(car_b), .gray_out(gray_b));
  counter_updown_mod #(.N(3), .MOD(8), .SATURATE(1'b0)) dut_c (
    .clk(clk), .reset_in(reset_in), .en_in(en_in), .load_in(load_in), .dir_in(dir_in),
    .d_in(d_in[2:0]), .count_out(cnt_c), .tc_out(tc_c), .carry_out(car_c), .gray_out(gray_c));
  counter_updown_mod #(.N(4), .MOD(11), .SATURATE(1'b0)) dut_d (
    .clk(clk), .reset_in(reset_in), .en_in(en_in), .load_in(load_in), .dir_in(dir_in),
    .d_in(d_in), .count_out(cnt_d), .tc_out(tc_d), .carry_out(car_d), .gray_out(gray_d));

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Model state per instance
  int mcnt[4];
  int mcar[4];
  int modv[4] = '{6, 8, 8, 11};
  int satv[4] = '{0, 1, 0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int i);
    case (i)
      0: return {29'd0, cnt_a};
      1: return {29'd0, cnt_b};
      2: return {29'd0, cnt_c};
      default: return {28'd0, cnt_d};
    endcase
  endfunction
  function automatic logic [31:0] dut_gray(input int i);
    case (i)
      0: return {29'd0, gray_a};
      1: return {29'd0, gray_b};
      2: return {29'd0, gray_c};
      default: return {28'd0, gray_d};
    endcase
  endfunction
  function automatic logic dut_tc(input int i);
    case (i)
      0: return tc_a;
      1: return tc_b;
      2: return tc_c;
      default: return tc_d;
    endcase
  endfunction
  function automatic logic dut_car(input int i);
    case (i)
      0: return car_a;
      1: return car_b;
      2: return car_c;
      default: return car_d;
    endcase
  endfunction

  // Behavioural rules applied at the edge, then every output compared 1ns later.
  task automatic cyc(input logic r, input logic l, input logic e, input logic dr, input logic [3:0] d);
    int dv, m, step;
    reset_in = r; load_in = l; en_in = e; dir_in = dr; d_in = d;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      m  = modv[i];
      dv = (i < 3) ? int'(d[2:0]) : int'(d);
      if (r) begin
        mcnt[i] = 0; mcar[i] = 0;
      end else if (l) begin
        mcnt[i] = (dv >= m) ? m - 1 : dv; mcar[i] = 0;
      end else if (e) begin
        step = dr ? 1 : -1;
        if ((dr && mcnt[i] == m - 1) || (!dr && mcnt[i] == 0)) begin
          mcar[i] = 1;
          if (satv[i] == 0) mcnt[i] = (mcnt[i] + step + m) % m;
        end else begin
          mcar[i] = 0;
          mcnt[i] = mcnt[i] + step;
        end
      end else begin
        mcar[i] = 0;
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      m = modv[i];
      chk($sformatf("count[%0d]", i), dut_cnt(i), mcnt[i]);
      chk($sformatf("carry[%0d]", i), {31'd0, dut_car(i)}, mcar[i]);
      chk($sformatf("tc[%0d]", i), {31'd0, dut_tc(i)},
          (dir_in ? (mcnt[i] == m - 1) : (mcnt[i] == 0)) ? 1 : 0);
      chk($sformatf("gray[%0d]", i), dut_gray(i), mcnt[i] ^ (mcnt[i] >> 1));
    end
  endtask

  int exp_up[8]   = '{1, 2, 3, 4, 5, 0, 1, 2};
  int exp_dn[4]   = '{1, 0, 5, 4};
  int exp_gray[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
  int exp_sat[3]  = '{7, 7, 7};
  logic [2:0] prev_gray;

  initial begin
    reset_in = 1'b1; load_in = 1'b0; en_in = 1'b0; dir_in = 1'b1; d_in = '0;
    for (int i = 0; i < 4; i++) begin mcnt[i] = 0; mcar[i] = 0; end

    // Reset state
    cyc(1, 0, 0, 1, 0);
    chk("rst_cnt_a", {29'd0, cnt_a}, 0);
    chk("rst_car_a", {31'd0, car_a}, 0);
    chk("rst_tc_a", {31'd0, tc_a}, 0);
    chk("rst_gray_c", {29'd0, gray_c}, 0);

    // Wrap up on A: 0..5,0,1,2 with carry only on the wrap to 0
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 1, 1, 0);
      chk("up_cnt_a", {29'd0, cnt_a}, exp_up[k]);
      chk("up_car_a", {31'd0, car_a}, (k == 5) ? 1 : 0);
      chk("up_tc_a", {31'd0, tc_a}, (k == 4) ? 1 : 0);
    end

    // Wrap down on A from a load of 2
    cyc(0, 1, 0, 0, 4'd2);
    chk("ld2_cnt_a", {29'd0, cnt_a}, 2);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 0, 0);
      chk("dn_cnt_a", {29'd0, cnt_a}, exp_dn[k]);
      chk("dn_car_a", {31'd0, car_a}, (k == 2) ? 1 : 0);
    end

    // Saturate on B: load 6, up three, then one step down
    cyc(0, 1, 0, 1, 4'd6);
    chk("ld6_cnt_b", {29'd0, cnt_b}, 6);
    chk("ld6_car_b", {31'd0, car_b}, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 1, 0);
      chk("sat_cnt_b", {29'd0, cnt_b}, exp_sat[k]);
      chk("sat_car_b", {31'd0, car_b}, (k == 0) ? 0 : 1);
    end
    cyc(0, 0, 1, 0, 0);
    chk("satdn_cnt_b", {29'd0, cnt_b}, 6);
    chk("satdn_car_b", {31'd0, car_b}, 0);

    // Load clamp and load-over-enable priority
    cyc(0, 1, 0, 1, 4'd7);
    chk("clamp_cnt_a", {29'd0, cnt_a}, 5);
    chk("clamp_tc_a", {31'd0, tc_a}, 1);
    chk("clamp_car_a", {31'd0, car_a}, 0);
    chk("noclamp_cnt_b", {29'd0, cnt_b}, 7);
    cyc(0, 1, 0, 1, 4'd15);
    chk("clamp_cnt_d", {28'd0, cnt_d}, 10);
    cyc(0, 1, 1, 1, 4'd2);
    chk("ldpri_cnt_a", {29'd0, cnt_a}, 2);

    // Reset dominance from count 4
    cyc(0, 1, 0, 1, 4'd4);
    chk("pre_rst_cnt_a", {29'd0, cnt_a}, 4);
    cyc(1, 1, 1, 1, 4'd3);
    chk("rstdom_cnt_a", {29'd0, cnt_a}, 0);
    chk("rstdom_car_a", {31'd0, car_a}, 0);

    // Gray sequence on C over a full up cycle
    prev_gray = gray_c;
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 1, 1, 0);
      chk("gray_c", {29'd0, gray_c}, exp_gray[k]);
      chk("gray_c_onebit", $countones(gray_c ^ prev_gray), 1);
      prev_gray = gray_c;
    end

    // Randomised traffic, including reset release with enable held
    for (int k = 0; k < 2000; k++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
